rr_arbiter_4: RTL and testbench

//  Four-requester round-robin arbiter. Grants one requester exclusive use of a shared resource.

---
 rtl/rr_arbiter_4.sv | 137 +++++++++++++
 tb/tb_rr_arbiter_4.sv | 135 +++++++++++++
 2 files changed

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with registered one-hot grant, encoded index,
// optional hold-time limit and a one-cycle turnaround gap between owners.
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam bit               TO_EN     = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = TO_EN ? CNT_W'(MAX_HOLD - 1) : '0;

  state_t           state_r, state_s;
  logic [1:0]       ptr_r, ptr_s;
  logic [1:0]       owner_r, owner_s;
  logic [CNT_W-1:0] hold_cnt_r, hold_cnt_s;
  logic [3:0]       gnt_s;
  logic [1:0]       gnt_idx_s;
  logic             gnt_valid_s;
  logic             timeout_s;
  logic [2:0]       pick_s;

  // Returns {found, index} of the first set request scanning ptr, ptr+1, ... (mod 4).
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] c;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      c = p + 2'(i);
      if (r[c]) begin
        res = {1'b1, c};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Rotating-priority winner for the IDLE arbitration cycle.
  always_comb begin
    pick_s = pick(req, ptr_r);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    owner_s     = owner_r;
    hold_cnt_s  = hold_cnt_r;
    gnt_s       = gnt;
    gnt_idx_s   = gnt_idx;
    gnt_valid_s = gnt_valid;
    timeout_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_s[2]) begin
          state_s     = GRANT;
          owner_s     = pick_s[1:0];
          hold_cnt_s  = '0;
          gnt_s       = 4'b0001 << pick_s[1:0];
          gnt_idx_s   = pick_s[1:0];
          gnt_valid_s = 1'b1;
        end else begin
          gnt_s       = 4'b0000;
          gnt_idx_s   = 2'd0;
          gnt_valid_s = 1'b0;
        end
      end
      GRANT: begin
        // Release wins over revoke: a revoke requires the owner to still be requesting.
        if (!req[owner_r]) begin
          state_s     = GAP;
          gnt_s       = 4'b0000;
          gnt_idx_s   = 2'd0;
          gnt_valid_s = 1'b0;
        end else if (TO_EN && (hold_cnt_r == HOLD_LAST)) begin
          state_s     = GAP;
          gnt_s       = 4'b0000;
          gnt_idx_s   = 2'd0;
          gnt_valid_s = 1'b0;
          timeout_s   = 1'b1;
        end else begin
          hold_cnt_s  = hold_cnt_r + CNT_W'(1);
        end
      end
      GAP: begin
        state_s     = IDLE;
        ptr_s       = owner_r + 2'd1;
        gnt_s       = 4'b0000;
        gnt_idx_s   = 2'd0;
        gnt_valid_s = 1'b0;
      end
      default: begin
        state_s     = IDLE;
        gnt_s       = 4'b0000;
        gnt_idx_s   = 2'd0;
        gnt_valid_s = 1'b0;
      end
    endcase
  end

  // State, pointer, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      ptr_r      <= 2'd0;
      owner_r    <= 2'd0;
      hold_cnt_r <= '0;
      gnt        <= 4'b0000;
      gnt_idx    <= 2'd0;
      gnt_valid  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_s;
      owner_r    <= owner_s;
      hold_cnt_r <= hold_cnt_s;
      gnt        <= gnt_s;
      gnt_idx    <= gnt_idx_s;
      gnt_valid  <= gnt_valid_s;
      timeout    <= timeout_s;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4: one instance with MAX_HOLD=16, one with the limit disabled.
module tb_rr_arbiter_4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, req0;
  logic [3:0] gnt, gnt0;
  logic [1:0] gnt_idx, gnt_idx0;
  logic       gnt_valid, gnt_valid0;
  logic       timeout, timeout0;
  logic [7:0] o, o0;
  logic [1:0] order [5];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  rr_arbiter_4 #(.MAX_HOLD(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  rr_arbiter_4 #(.MAX_HOLD(0), .CNT_W(5)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0),
    .gnt(gnt0), .gnt_idx(gnt_idx0), .gnt_valid(gnt_valid0), .timeout(timeout0)
  );

  assign o  = {timeout, gnt_valid, gnt_idx, gnt};
  assign o0 = {timeout0, gnt_valid0, gnt_idx0, gnt0};

  function automatic logic [7:0] ex(input logic t, input logic v, input logic [1:0] i,
                                    input logic [3:0] g);
    return {t, v, i, g};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed={to,v,idx,gnt}=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    req0  = 4'b0000;
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Reset and idle
    repeat (3) begin
      step();
      chk("reset", o, 8'h00);
      chk("reset_nolimit", o0, 8'h00);
    end
    rst_n = 1'b1;
    repeat (2) begin
      step();
      chk("idle_no_req", o, 8'h00);
    end

    // Single request, release, GAP, pointer moves to 3
    req = 4'b0100;
    step(); chk("single_grant", o, ex(1'b0, 1'b1, 2'd2, 4'b0100));
    req = 4'b0000;
    step(); chk("release_gap", o, 8'h00);
    req = 4'b1001;
    step(); chk("gap_idle", o, 8'h00);
    step(); chk("ptr3_grant", o, ex(1'b0, 1'b1, 2'd3, 4'b1000));
    req = 4'b0000;
    step(); chk("release3_gap", o, 8'h00);
    step(); chk("release3_idle", o, 8'h00);

    // All requesting, each owner drops after 3 cycles then re-raises
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      for (int c = 1; c <= 3; c++) begin
        step();
        chk("rr_hold", o, ex(1'b0, 1'b1, order[k], 4'b0001 << order[k]));
        if (c == 3) req[order[k]] = 1'b0;
      end
      step(); chk("rr_gap", o, 8'h00);
      req = 4'b1111;
      step(); chk("rr_idle", o, 8'h00);
    end

    // Hold limit: owner 1 holds forever, requester 2 waits
    req = 4'b0110;
    repeat (16) begin
      step(); chk("hold16", o, ex(1'b0, 1'b1, 2'd1, 4'b0010));
    end
    step(); chk("timeout_pulse", o, ex(1'b1, 1'b0, 2'd0, 4'b0000));
    step(); chk("timeout_idle", o, 8'h00);
    step(); chk("after_timeout", o, ex(1'b0, 1'b1, 2'd2, 4'b0100));
    req = 4'b1000;
    step(); chk("to3_gap", o, 8'h00);
    step(); chk("to3_idle", o, 8'h00);
    step(); chk("owner3", o, ex(1'b0, 1'b1, 2'd3, 4'b1000));

    // Asynchronous reset mid-grant
    #2 rst_n = 1'b0;
    #1 chk("async_reset", o, 8'h00);
    step(); chk("in_reset", o, 8'h00);
    rst_n = 1'b1;
    req   = 4'b1010;
    step(); chk("post_reset_ptr0", o, ex(1'b0, 1'b1, 2'd1, 4'b0010));

    // Release on the same edge the limit would fire: no timeout
    for (int c = 2; c <= 16; c++) begin
      step(); chk("hold_to_edge", o, ex(1'b0, 1'b1, 2'd1, 4'b0010));
      if (c == 16) req = 4'b1000;
    end
    step(); chk("release_at_limit", o, 8'h00);
    step(); chk("release_at_limit_idle", o, 8'h00);
    step(); chk("after_release_limit", o, ex(1'b0, 1'b1, 2'd3, 4'b1000));
    req = 4'b0000;
    step(); chk("final_gap", o, 8'h00);

    // No limit: requester 0 held for 100 cycles
    req0 = 4'b0001;
    repeat (100) begin
      step(); chk("no_limit", o0, ex(1'b0, 1'b1, 2'd0, 4'b0001));
    end
    req0 = 4'b0000;
    step(); chk("no_limit_release", o0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
